// File: rtl/mul16_seq_ctrl_if.sv
// Request/response and shared 8x8 core signals of mul16_seq_ctrl.
// The sequencer takes the slave view; the requester/core side takes the master view.
interface mul16_seq_ctrl_if;
    logic        start;
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  mul_x;
    logic [7:0]  mul_y;
    logic        mul_sel;
    logic [15:0] mul_p;
    logic        busy;
    logic        done;
    logic [31:0] c;

    modport slave (
        input  start, mode, a, b, mul_p,
        output mul_x, mul_y, mul_sel, busy, done, c
    );

    modport master (
        output start, mode, a, b, mul_p,
        input  mul_x, mul_y, mul_sel, busy, done, c
    );
endinterface

// File: rtl/mul16_seq_ctrl.sv
// 16x16 unsigned multiply sequenced over one shared 8x8 core: exact (four partial
// products) or error-tolerant (exact high bytes, approximate low bytes, no carry).
module mul16_seq_ctrl (
    input  logic                    clk,
    input  logic                    rst,
    mul16_seq_ctrl_if.slave         bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StLl,
        StLh,
        StHl,
        StHh,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        mode_q, mode_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] c_q, c_d;

    logic [7:0]  mul_x;
    logic [7:0]  mul_y;
    logic        mul_sel;
    logic        busy;
    logic        done;
    logic [31:0] prod_ext;

    assign prod_ext = {16'h0000, bus_io.mul_p};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        c_d     = c_q;
        mul_x   = '0;
        mul_y   = '0;
        mul_sel = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            // DONE accepts a new request exactly like IDLE for back-to-back use.
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (bus_io.start) begin
                    a_d    = bus_io.a;
                    b_d    = bus_io.b;
                    mode_d = bus_io.mode;
                    if ((bus_io.a == 16'h0000) || (bus_io.b == 16'h0000)) begin
                        c_d     = '0;
                        state_d = StDone;
                    end else begin
                        acc_d   = '0;
                        state_d = StLl;
                    end
                end else begin
                    state_d = StIdle;
                end
            end

            StLl: begin
                busy    = 1'b1;
                mul_x   = a_q[7:0];
                mul_y   = b_q[7:0];
                mul_sel = mode_q;
                if (mode_q) begin
                    acc_d[15:0] = bus_io.mul_p;
                    state_d     = StHh;
                end else begin
                    acc_d   = prod_ext;
                    state_d = StLh;
                end
            end

            StLh: begin
                busy    = 1'b1;
                mul_x   = a_q[7:0];
                mul_y   = b_q[15:8];
                acc_d   = acc_q + (prod_ext << 8);
                state_d = StHl;
            end

            StHl: begin
                busy    = 1'b1;
                mul_x   = a_q[15:8];
                mul_y   = b_q[7:0];
                acc_d   = acc_q + (prod_ext << 8);
                state_d = StHh;
            end

            StHh: begin
                busy  = 1'b1;
                mul_x = a_q[15:8];
                mul_y = b_q[15:8];
                if (mode_q) begin
                    c_d = {bus_io.mul_p, acc_q[15:0]};
                end else begin
                    c_d = acc_q + (prod_ext << 16);
                end
                state_d = StDone;
            end

            default: state_d = StIdle;
        endcase
    end

    assign bus_io.mul_x   = mul_x;
    assign bus_io.mul_y   = mul_y;
    assign bus_io.mul_sel = mul_sel;
    assign bus_io.busy    = busy;
    assign bus_io.done    = done;
    assign bus_io.c       = c_q;

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Bench for mul16_seq_ctrl: vector table, directed multi-cycle sequences and random
// operations against an arithmetic reference model; the bench also plays the 8x8 cores.
module tb_mul16_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic force_abcd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tr_x    [16];
    logic [7:0] tr_y    [16];
    logic       tr_sel  [16];
    logic       tr_busy [16];

    always #5 clk = ~clk;

    mul16_seq_ctrl_if bus ();

    mul16_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    // Approximate core stand-in: any deterministic function of x, y will do.
    function automatic logic [15:0] approx8(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = 16'(x) * 16'(y);
        return p | 16'h0007;
    endfunction

    assign bus.mul_p = bus.mul_sel ? (force_abcd ? 16'hABCD : approx8(bus.mul_x, bus.mul_y))
                                   : 16'(bus.mul_x) * 16'(bus.mul_y);

    function automatic logic [31:0] ref_c(input logic m, input logic [15:0] av,
                                          input logic [15:0] bv, input logic fab);
        logic [15:0] hi, lo;
        if (av == 16'h0 || bv == 16'h0) return 32'h0;
        if (!m) return 32'(av) * 32'(bv);
        hi = 16'(av[15:8]) * 16'(bv[15:8]);
        lo = fab ? 16'hABCD : approx8(av[7:0], bv[7:0]);
        return {hi, lo};
    endfunction

    function automatic int ref_lat(input logic m, input logic [15:0] av, input logic [15:0] bv);
        if (av == 16'h0 || bv == 16'h0) return 1;
        return m ? 3 : 5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request, then trace the cycles after acceptance until done (bounded).
    task automatic run_op(input logic m, input logic [15:0] av, input logic [15:0] bv,
                          output logic [31:0] cv, output int lat, output logic [31:0] bvec);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.mode  = 1'($urandom);
        lat  = 0;
        cv   = '0;
        bvec = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            tr_x[k]    = bus.mul_x;
            tr_y[k]    = bus.mul_y;
            tr_sel[k]  = bus.mul_sel;
            tr_busy[k] = bus.busy;
            bvec[k-1]  = bus.busy;
            if (bus.done) begin
                lat = k;
                cv  = bus.c;
                break;
            end
        end
    endtask

    typedef struct {
        logic        mode;
        logic [15:0] a;
        logic [15:0] b;
        logic        fab;
        logic [31:0] exp_c;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] cv, bvec, exp_c;
        int          lat, lat2, exp_lat, pulses;
        logic        m;
        logic [15:0] av, bv;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cv, bvec;
        int          lat, lat2, exp_lat, pulses;
        logic        m;
        logic [15:0] av, bv;

        vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 5};
        vecs[1] = '{1'b1, 16'h1234, 16'h5678, 1'b1, 32'h060C_ABCD, 3};
        vecs[2] = '{1'b0, 16'h0000, 16'h1234, 1'b0, 32'h0000_0000, 1};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 32'h0000_0000, 1};
        vecs[4] = '{1'b0, 16'h0003, 16'h0005, 1'b0, 32'h0000_000F, 5};
        vecs[5] = '{1'b0, 16'h0100, 16'h0100, 1'b0, 32'h0001_0000, 5};
        vecs[6] = '{1'b1, 16'h0100, 16'h0100, 1'b0, 32'h0001_0007, 3};

        force_abcd = 1'b0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_c", bus.c, 32'h0);
        check("rst_xy_sel", {15'h0, bus.mul_sel, bus.mul_x, bus.mul_y}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            force_abcd = vecs[i].fab;
            run_op(vecs[i].mode, vecs[i].a, vecs[i].b, cv, lat, bvec);
            check($sformatf("vec%0d_c", i), cv, vecs[i].exp_c);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy", i), bvec, (32'd1 << (vecs[i].exp_lat - 1)) - 32'd1);
            if (i == 0) begin
                for (int k = 1; k <= 4; k++)
                    check($sformatf("max_trace%0d", k),
                          {15'h0, tr_sel[k], tr_x[k], tr_y[k]}, 32'h0000_FFFF);
            end
            if (i == 1) begin
                check("etm_ll", {15'h0, tr_sel[1], tr_x[1], tr_y[1]}, 32'h0001_3478);
                check("etm_hh", {15'h0, tr_sel[2], tr_x[2], tr_y[2]}, 32'h0000_1256);
            end
            if (i == 2) check("zero_xy", {15'h0, tr_sel[1], tr_x[1], tr_y[1]}, 32'h0);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'h0);
            check($sformatf("vec%0d_c_hold", i), bus.c, vecs[i].exp_c);
        end
        force_abcd = 1'b0;

        // Start pulsed mid-operation must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.a = 16'h0003; bus.b = 16'h0005;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 16'hFFFF;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("ign_done", 32'(bus.done), 32'h1);
        check("ign_c", bus.c, 32'h0000_000F);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("ign_no_second_done", 32'(pulses), 32'h0);

        // Back-to-back: start held, next operands presented in the done cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.a = 16'h0002; bus.b = 16'h0003;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done) begin lat = k; break; end
        end
        check("b2b_lat1", 32'(lat), 32'd5);
        check("b2b_c1", bus.c, 32'h6);
        bus.a = 16'h0100; bus.b = 16'h0100;
        @(posedge clk); #1; bus.start = 1'b0;
        lat2 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done) begin lat2 = k; break; end
        end
        check("b2b_lat2", 32'(lat2), 32'd5);
        check("b2b_c2", bus.c, 32'h0001_0000);

        // Reset in the middle of an exact operation.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.a = 16'h1234; bus.b = 16'h4321;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        check("rmid_busy_before", 32'(bus.busy), 32'h1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rmid_busy", 32'(bus.busy), 32'h0);
        check("rmid_done", 32'(bus.done), 32'h0);
        check("rmid_c", bus.c, 32'h0);
        check("rmid_xy_sel", {15'h0, bus.mul_sel, bus.mul_x, bus.mul_y}, 32'h0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("rmid_no_done", 32'(pulses), 32'h0);
        run_op(1'b0, 16'h1234, 16'h4321, cv, lat, bvec);
        check("rmid_after_c", cv, ref_c(1'b0, 16'h1234, 16'h4321, 1'b0));
        check("rmid_after_lat", 32'(lat), 32'd5);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            m  = 1'($urandom);
            av = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            exp_lat = ref_lat(m, av, bv);
            run_op(m, av, bv, cv, lat, bvec);
            check($sformatf("rnd%0d_c m=%0d a=%h b=%h", i, m, av, bv), cv,
                  ref_c(m, av, bv, 1'b0));
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_busy", i), bvec, (32'd1 << (exp_lat - 1)) - 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
